// File: rtl/qam_mapper_multi.sv
// qam_mapper_multi: bit-serial BPSK/QPSK/16QAM/64QAM mapper with valid/ready on both sides
module qam_mapper_multi #(
  parameter int OUT_W = 11,
  parameter int SCALE = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [1:0]              mode_i,
  input  logic                    valid_i,
  input  logic                    data_i,
  output logic                    in_ready,
  output logic                    valid_x,
  input  logic                    ready_x,
  output logic signed [OUT_W-1:0] xr,
  output logic signed [OUT_W-1:0] xi
);
  logic [2:0] cnt_q, cnt_d, k_eff, i_mag, q_mag;
  logic [4:0] sh_q, sh_d;
  logic [5:0] b;
  logic [1:0] mode_q, mode_d, mode_e;
  logic vld_q, vld_d, last, xfer, done, i_neg, q_neg;
  logic signed [4:0] i_lvl, q_lvl;
  logic signed [OUT_W-1:0] xr_q, xr_d, xi_q, xi_d;

  function automatic logic [2:0] gray(input logic a, input logic c);
    return a ? (c ? 3'd3 : 3'd1) : (c ? 3'd5 : 3'd7);
  endfunction

  always_comb begin
    mode_e = cnt_q == 3'd0 ? mode_i : mode_q;
    k_eff = mode_e == 2'd0 ? 3'd1 : mode_e == 2'd1 ? 3'd2 : mode_e == 2'd2 ? 3'd4 : 3'd6;
    last = cnt_q == k_eff - 3'd1;
    in_ready = !(last && vld_q && !ready_x);
    xfer = valid_i && in_ready;
    done = xfer && last;
    // b holds the symbol bits right-aligned, including the bit arriving now
    b = {sh_q, data_i};
    i_neg = mode_e == 2'd0 ? b[0] : mode_e == 2'd1 ? b[1] : mode_e == 2'd2 ? b[3] : b[5];
    q_neg = mode_e == 2'd1 ? b[0] : mode_e == 2'd2 ? b[2] : b[4];
    i_mag = mode_e == 2'd3 ? gray(b[3], b[1]) : mode_e == 2'd2 ? (b[1] ? 3'd1 : 3'd3) : 3'd1;
    q_mag = mode_e == 2'd3 ? gray(b[2], b[0]) : mode_e == 2'd2 ? (b[0] ? 3'd1 : 3'd3) :
            mode_e == 2'd1 ? 3'd1 : 3'd0;
    i_lvl = i_neg ? -$signed({2'b00, i_mag}) : $signed({2'b00, i_mag});
    q_lvl = q_neg ? -$signed({2'b00, q_mag}) : $signed({2'b00, q_mag});
    cnt_d = !xfer ? cnt_q : last ? 3'd0 : cnt_q + 3'd1;
    sh_d = xfer ? b[4:0] : sh_q;
    mode_d = xfer && cnt_q == 3'd0 ? mode_i : mode_q;
    vld_d = done || (vld_q && !ready_x);
    xr_d = done ? OUT_W'(i_lvl * SCALE) : xr_q;
    xi_d = done ? OUT_W'(q_lvl * SCALE) : xi_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
      sh_q <= '0;
      mode_q <= '0;
      vld_q <= 1'b0;
      xr_q <= '0;
      xi_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      mode_q <= mode_d;
      vld_q <= vld_d;
      xr_q <= xr_d;
      xi_q <= xi_d;
    end
  end

  assign valid_x = vld_q;
  assign xr = xr_q;
  assign xi = xi_q;
endmodule

// File: tb/tb_qam_mapper_multi.sv
// tb_qam_mapper_multi: directed and random stimulus against a behavioural symbol model
module tb_qam_mapper_multi;
  localparam int OUT_W = 11;
  localparam int SCALE = 2;

  logic CLK = 1'b0, RST = 1'b0, valid_i = 1'b0, data_i = 1'b0, ready_x = 1'b1;
  logic [1:0] mode_i = 2'd0;
  logic in_ready, valid_x;
  logic signed [OUT_W-1:0] xr, xi;

  qam_mapper_multi #(.OUT_W(OUT_W), .SCALE(SCALE)) dut (
    .CLK(CLK), .RST(RST), .mode_i(mode_i), .valid_i(valid_i), .data_i(data_i),
    .in_ready(in_ready), .valid_x(valid_x), .ready_x(ready_x), .xr(xr), .xi(xi)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0, n_chk = 0;
  bit en = 1'b0;
  int m_cnt = 0, m_bits = 0, m_xr = 0, m_xi = 0;
  logic [1:0] m_mode = 2'd0;
  bit m_v = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int kbits(input logic [1:0] m);
    return m == 2'd0 ? 1 : m == 2'd1 ? 2 : m == 2'd2 ? 4 : 6;
  endfunction

  function automatic int sgn(input int v, input int pos);
    return v[pos] ? -1 : 1;
  endfunction

  // Symbol value from its bits b[K-1]..b0 held in v, using the constellation tables directly
  function automatic void map_sym(input logic [1:0] m, input int v, output int i, output int q);
    int g[4];
    g = '{7, 5, 1, 3};
    case (m)
      2'd0: begin i = v[0] ? -1 : 1; q = 0; end
      2'd1: begin i = sgn(v, 1); q = sgn(v, 0); end
      2'd2: begin i = sgn(v, 3) * (v[1] ? 1 : 3); q = sgn(v, 2) * (v[0] ? 1 : 3); end
      default: begin i = sgn(v, 5) * g[{v[3], v[1]}]; q = sgn(v, 4) * g[{v[2], v[0]}]; end
    endcase
    i = i * SCALE;
    q = q * SCALE;
  endfunction

  always @(negedge CLK) begin
    int k, si, sq;
    bit rdy;
    k = kbits(m_cnt == 0 ? mode_i : m_mode);
    rdy = !(m_cnt == k - 1 && m_v && !ready_x);
    if (en) begin
      chk("in_ready", in_ready, rdy);
      chk("valid_x", valid_x, m_v);
      chk("xr", xr, m_xr);
      chk("xi", xi, m_xi);
    end
    if (!RST) begin
      m_cnt = 0; m_bits = 0; m_mode = 2'd0; m_v = 1'b0; m_xr = 0; m_xi = 0;
    end else if (valid_i && rdy) begin
      if (m_cnt == 0) m_mode = mode_i;
      m_bits = m_bits * 2 + int'(data_i);
      m_cnt++;
      if (m_cnt == kbits(m_mode)) begin
        map_sym(m_mode, m_bits, si, sq);
        m_xr = si; m_xi = sq; m_v = 1'b1; m_cnt = 0; m_bits = 0;
      end else if (ready_x) m_v = 1'b0;
    end else if (ready_x) m_v = 1'b0;
  end

  task automatic send_bit(input logic [1:0] m, input logic bv);
    int n;
    n = 0;
    mode_i = m; data_i = bv; valid_i = 1'b1;
    @(negedge CLK);
    while (!in_ready && n < 50) begin n++; @(negedge CLK); end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge CLK); #1;
    valid_i = 1'b0;
  endtask

  task automatic send_sym(input logic [1:0] m, input logic [5:0] v, input int k);
    for (int i = k - 1; i >= 0; i--) send_bit(m, v[i]);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    en = 1'b1;
    chk("rst_valid_x", valid_x, 0);
    chk("rst_xr", xr, 0);
    RST = 1'b1;
    send_sym(2'd2, 6'b0001, 4);
    chk("t1_valid_x", valid_x, 1);
    chk("t1_xr", xr, 6);
    chk("t1_xi", xi, 2);
    send_sym(2'd3, 6'b101101, 6);
    chk("t2a_xr", xr, -2);
    chk("t2a_xi", xi, 6);
    send_sym(2'd3, 6'b000000, 6);
    chk("t2b_xr", xr, 14);
    chk("t2b_xi", xi, 14);
    send_sym(2'd3, 6'b111010, 6);
    chk("t2c_xr", xr, -6);
    chk("t2c_xi", xi, -14);
    send_bit(2'd0, 1'b1);
    chk("t3a_xr", xr, -2);
    send_bit(2'd0, 1'b0);
    chk("t3b_xr", xr, 2);
    chk("t3b_valid_x", valid_x, 1);
    send_bit(2'd0, 1'b1);
    chk("t3c_xr", xr, -2);
    chk("t3c_xi", xi, 0);
    send_sym(2'd1, 6'b10, 2);
    chk("t3d_xr", xr, -2);
    chk("t3d_xi", xi, 2);
    @(posedge CLK); #1;
    ready_x = 1'b0;
    send_sym(2'd2, 6'b1001, 4);
    send_bit(2'd2, 1'b0);
    send_bit(2'd2, 1'b1);
    send_bit(2'd2, 1'b1);
    mode_i = 2'd2; data_i = 1'b0; valid_i = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("t4_stall_in_ready", in_ready, 0);
      chk("t4_hold_xr", xr, -6);
      chk("t4_hold_xi", xi, 2);
    end
    @(posedge CLK); #1;
    ready_x = 1'b1;
    @(negedge CLK);
    chk("t4_release_in_ready", in_ready, 1);
    @(posedge CLK); #1;
    valid_i = 1'b0;
    chk("t4_second_valid_x", valid_x, 1);
    chk("t4_second_xr", xr, 2);
    chk("t4_second_xi", xi, -6);
    send_bit(2'd2, 1'b1);
    send_bit(2'd3, 1'b0);
    send_bit(2'd3, 1'b1);
    send_bit(2'd3, 1'b1);
    chk("t5a_xr", xr, -2);
    chk("t5a_xi", xi, 2);
    send_sym(2'd3, 6'b010011, 6);
    chk("t5b_xr", xr, 10);
    chk("t5b_xi", xi, -10);
    ready_x = 1'b0;
    send_bit(2'd3, 1'b1);
    send_bit(2'd3, 1'b1);
    send_bit(2'd3, 1'b0);
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    chk("t6_valid_x", valid_x, 0);
    chk("t6_xr", xr, 0);
    chk("t6_xi", xi, 0);
    ready_x = 1'b1;
    send_sym(2'd3, 6'b101101, 6);
    chk("t6_fresh_xr", xr, -2);
    chk("t6_fresh_xi", xi, 6);
    repeat (600) begin
      valid_i = $urandom_range(0, 3) != 0;
      data_i = 1'($urandom);
      mode_i = 2'($urandom);
      ready_x = $urandom_range(0, 2) != 0;
      RST = $urandom_range(0, 60) != 0;
      @(posedge CLK); #1;
    end
    RST = 1'b1; valid_i = 1'b0; ready_x = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
